dynamic_display_scan: RTL and testbench

Time-multiplexed driver for the two 4-digit 7-segment units of the board's dynamic display. It sits directly downstream of the IO write logic: it accepts 32-bit words of four packed ASCII characters and scans them onto 8-bit segment outputs and 4-bit digit-gate outputs, one pair per unit. It double-buffers the text so that updates take effect only at frame boundaries, with no tearing. A blanking interval between digits suppresses ghosting.

---
 rtl/dynamic_display_scan.sv | 195 +++++++++++++++++++
 tb/tb_dynamic_display_scan.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dynamic_display_scan.sv
// Scan driver for two 4-digit 7-segment units: double-buffered ASCII text,
// frame-aligned commits and a blanking gap at the head of every digit slot.

module dds_unit (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wr_en_i,
    input  logic [31:0] wr_data_i,
    input  logic        commit_i,
    input  logic        drive_i,
    input  logic [1:0]  dig_i,
    output logic [7:0]  seg_o,
    output logic [3:0]  gate_o,
    output logic        dirty_o
);
    localparam logic [31:0] SPACES = 32'h20202020;

    logic [31:0] pending_q, pending_d;
    logic [31:0] active_q, active_d;
    logic        dirty_q, dirty_d;
    logic [7:0]  char_sel;

    // Active-high {dp,g,f,e,d,c,b,a}; anything not listed is blank.
    function automatic logic [7:0] seg_decode(input logic [7:0] ch);
        logic [7:0] s;
        case (ch)
            8'h30: s = 8'h3F;
            8'h31: s = 8'h06;
            8'h32: s = 8'h5B;
            8'h33: s = 8'h4F;
            8'h34: s = 8'h66;
            8'h35: s = 8'h6D;
            8'h36: s = 8'h7D;
            8'h37: s = 8'h07;
            8'h38: s = 8'h7F;
            8'h39: s = 8'h6F;
            8'h41: s = 8'h77;
            8'h42: s = 8'h7C;
            8'h43: s = 8'h39;
            8'h44: s = 8'h5E;
            8'h45: s = 8'h79;
            8'h46: s = 8'h71;
            8'h2D: s = 8'h40;
            8'h5F: s = 8'h08;
            8'h2E: s = 8'h80;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // A write in the commit cycle wins the pending slot and keeps dirty set,
    // while the commit itself still takes the previous pending word.
    always_comb begin
        pending_d = pending_q;
        active_d  = active_q;
        dirty_d   = dirty_q;
        if (commit_i && dirty_q) active_d = pending_q;
        if (commit_i) dirty_d = 1'b0;
        if (wr_en_i) begin
            pending_d = wr_data_i;
            dirty_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= SPACES;
            active_q  <= SPACES;
            dirty_q   <= 1'b0;
        end else begin
            pending_q <= pending_d;
            active_q  <= active_d;
            dirty_q   <= dirty_d;
        end
    end

    always_comb begin
        case (dig_i)
            2'd0:    char_sel = active_q[31:24];
            2'd1:    char_sel = active_q[23:16];
            2'd2:    char_sel = active_q[15:8];
            default: char_sel = active_q[7:0];
        endcase
    end

    always_comb begin
        seg_o  = 8'hFF;
        gate_o = 4'hF;
        if (drive_i) begin
            seg_o  = ~seg_decode(char_sel);
            gate_o = ~(4'b0001 << dig_i);
        end
    end

    assign dirty_o = dirty_q;
endmodule

module dynamic_display_scan #(
    parameter int unsigned BLANK_CYCLES = 16,
    parameter logic [27:0] DEF_PERIOD   = 28'h3000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wrValid_i,
    input  logic        wrIndex_i,
    input  logic [31:0] wrData_i,
    input  logic [27:0] period_i,
    output logic [15:0] segOut_o,
    output logic [7:0]  gateOut_o,
    output logic        frameStart_o,
    output logic [1:0]  dirty_o
);
    localparam int          NUM_UNITS = 2;
    localparam logic [27:0] BLANK_M1  = 28'(BLANK_CYCLES - 1);
    localparam logic [27:0] MIN_PER   = 28'(BLANK_CYCLES + 1);

    typedef enum logic {BLANK, DRIVE} state_e;

    state_e      state_q, state_d;
    logic [27:0] cnt_q, cnt_d;
    logic [1:0]  dig_q, dig_d;
    logic [27:0] eff_q, eff_d;
    logic [15:0] seg_q, seg_d;
    logic [7:0]  gate_q, gate_d;
    logic        frame_q, frame_d;
    logic [27:0] per_pick;
    logic        slot_end;

    function automatic logic [27:0] clamp_period(input logic [27:0] p);
        return (p < MIN_PER) ? MIN_PER : p;
    endfunction

    assign per_pick = (period_i == 28'd0) ? DEF_PERIOD : period_i;
    assign slot_end = (state_q == DRIVE) && (cnt_q == eff_q - 28'd1);

    // State, slot counter and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BLANK;
            cnt_q   <= 28'd0;
            dig_q   <= 2'd0;
            eff_q   <= clamp_period(DEF_PERIOD);
            seg_q   <= 16'hFFFF;
            gate_q  <= 8'hFF;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            eff_q   <= eff_d;
            seg_q   <= seg_d;
            gate_q  <= gate_d;
            frame_q <= frame_d;
        end
    end

    // Slot length is sampled once at slot start so a mid-slot period change
    // cannot stretch or truncate the slot already in progress.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 28'd1;
        dig_d   = dig_q;
        eff_d   = (cnt_q == 28'd0) ? clamp_period(per_pick) : eff_q;
        case (state_q)
            BLANK: if (cnt_q == BLANK_M1) state_d = DRIVE;
            DRIVE: if (slot_end) begin
                state_d = BLANK;
                cnt_d   = 28'd0;
                dig_d   = dig_q + 2'd1;
            end
            default: state_d = BLANK;
        endcase
    end

    for (genvar n = 0; n < NUM_UNITS; n++) begin : g_unit
        dds_unit u_unit (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .wr_en_i   (wrValid_i && (wrIndex_i == 1'(n))),
            .wr_data_i (wrData_i),
            .commit_i  (frame_q),
            .drive_i   (state_q == DRIVE),
            .dig_i     (dig_q),
            .seg_o     (seg_d[n*8 +: 8]),
            .gate_o    (gate_d[n*4 +: 4]),
            .dirty_o   (dirty_o[n])
        );
    end

    assign frame_d = (cnt_q == 28'd0) && (dig_q == 2'd0);

    assign segOut_o     = seg_q;
    assign gateOut_o    = gate_q;
    assign frameStart_o = frame_q;
endmodule

// File: tb/tb_dynamic_display_scan.sv
// Directed bench for dynamic_display_scan: reset, scan, commit timing,
// decode, blanking shape and period handling.

module tb_dynamic_display_scan;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_index = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic [27:0] period = 28'd64;
    logic [15:0] seg;
    logic [7:0]  gate;
    logic        frame;
    logic [1:0]  dirty;

    int n_tests = 0;
    int n_fail  = 0;

    dynamic_display_scan dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .wrValid_i    (wr_valid),
        .wrIndex_i    (wr_index),
        .wrData_i     (wr_data),
        .period_i     (period),
        .segOut_o     (seg),
        .gateOut_o    (gate),
        .frameStart_o (frame),
        .dirty_o      (dirty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic idx, input logic [31:0] d);
        wr_valid = 1'b1;
        wr_index = idx;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // Ticks until frameStart is seen; n is the number of cycles advanced.
    task automatic wait_fs(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame && n < max);
        chk("fs_seen", {31'd0, frame}, 32'd1);
    endtask

    initial begin
        int n;
        logic [3:0] g;
        logic [7:0] gexp;

        adv(3);
        chk("rst_seg", seg, 16'hFFFF);
        chk("rst_gate", gate, 8'hFF);
        chk("rst_fs", frame, 1'b0);
        chk("rst_dirty", dirty, 2'b00);

        // First frame after release
        rst_n = 1'b1;
        tick();
        chk("first_fs", frame, 1'b1);
        chk("first_gate", gate, 8'hFF);
        for (int c = 1; c < 16; c++) begin
            tick();
            chk("first_blank_gate", gate, 8'hFF);
        end
        tick();
        chk("first_drive_gate", gate, 8'hEE);
        chk("first_drive_seg", seg, 16'hFFFF);
        chk("first_drive_fs", frame, 1'b0);

        // Write "12AF" to unit 0, visible from next frame
        wr(1'b0, 32'h31324146);
        chk("wr_dirty", dirty, 2'b01);
        chk("wr_not_yet", seg, 16'hFFFF);
        wait_fs(300, n);
        chk("frame_len_64", n, 239);
        chk("dirty_at_fs", dirty, 2'b01);
        tick();
        chk("dirty_cleared", dirty, 2'b00);
        adv(15);
        chk("d0_gate", gate, 8'hEE);
        chk("d0_seg", seg, 16'hFFF9);
        adv(64);
        chk("d1_gate", gate, 8'hDD);
        chk("d1_seg", seg, 16'hFFA4);
        adv(64);
        chk("d2_gate", gate, 8'hBB);
        chk("d2_seg", seg, 16'hFF88);
        adv(64);
        chk("d3_gate", gate, 8'h77);
        chk("d3_seg", seg, 16'hFF8E);
        adv(47);
        chk("d3_last_gate", gate, 8'h77);
        tick();
        chk("wrap_fs", frame, 1'b1);
        chk("wrap_gate", gate, 8'hFF);

        // Write in the commit cycle is deferred one frame
        wr(1'b1, 32'h38383838);
        chk("cc_dirty", dirty, 2'b10);
        adv(15);
        chk("cc_old_seg", seg, 16'hFFF9);
        wait_fs(300, n);
        chk("cc_frame_len", n, 240);
        chk("cc_dirty_fs", dirty, 2'b10);
        tick();
        chk("cc_dirty_clr", dirty, 2'b00);
        adv(15);
        chk("cc_new_seg", seg, 16'h80F9);
        chk("cc_new_gate", gate, 8'hEE);

        // Decode sweep: unit0 "-_ .", unit1 "z0B9"
        wr(1'b0, 32'h2D5F202E);
        wr(1'b1, 32'h7A304239);
        chk("dec_dirty", dirty, 2'b11);
        wait_fs(300, n);
        chk("dec_frame_len", n, 238);
        adv(16);
        chk("dec_d0", seg, 16'hFFBF);
        adv(64);
        chk("dec_d1", seg, 16'hC0F7);
        adv(64);
        chk("dec_d2", seg, 16'h83FF);
        adv(64);
        chk("dec_d3", seg, 16'h907F);

        // Whole-frame gate shape
        wait_fs(300, n);
        chk("shape_align", n, 48);
        for (int c = 0; c < 256; c++) begin
            g = ~(4'b0001 << (c / 64));
            gexp = ((c % 64) < 16) ? 8'hFF : {g, g};
            chk("shape_gate", gate, gexp);
            tick();
        end
        chk("shape_fs", frame, 1'b1);

        // Mid-slot period change: slot 0 stays 64, rest 20
        adv(5);
        period = 28'd20;
        wait_fs(500, n);
        chk("midslot_len", n, 119);

        // period=5 clamps to 17; first frame still has a 20-cycle slot 0
        period = 28'd5;
        wait_fs(500, n);
        chk("mixed_len", n, 71);
        wait_fs(500, n);
        chk("clamp_len", n, 68);

        // period=0 selects the default
        adv(51);
        period = 28'd0;
        wait_fs(100, n);
        chk("clamp_tail", n, 17);
        wait_fs(60000, n);
        chk("default_len", n, 49152);

        // Reset in the middle of a DRIVE phase
        period = 28'd64;
        adv(20);
        chk("pre_rst_gate", gate, 8'hEE);
        chk("pre_rst_seg", seg, 16'hFFBF);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_seg", seg, 16'hFFFF);
        chk("mid_rst_gate", gate, 8'hFF);
        chk("mid_rst_fs", frame, 1'b0);
        adv(2);
        rst_n = 1'b1;
        tick();
        chk("rerun_fs", frame, 1'b1);
        adv(16);
        chk("rerun_gate", gate, 8'hEE);
        chk("rerun_seg", seg, 16'hFFFF);
        wait_fs(300, n);
        chk("rerun_len", n, 240);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
